switch_ctrl_gen: RTL

Streaming front-end for one commutator stage of the matrix-transpose network. It takes a 2-lane valid-qualified sample stream and delays lane 1 by DELAY valid samples. It generates the cross/pass control that toggles every DELAY samples and presents the aligned triple (ctrl, lane 0, lane 1) to the downstream switch_2_2 instance. Cascading these stages with power-of-two DELAY values builds the full transpose permutation.

---
 rtl/switch_ctrl_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/switch_ctrl_gen.sv
// switch_ctrl_gen: commutator front-end for one transpose stage.
// Delays lane 1 by DELAY accepted samples and generates the pass/cross
// control for the downstream switch_2_2, toggling every DELAY samples.
// Optional macro SWITCH_CTRL_WARMUP_MASK_EN: suppresses out_valid until the
// lane-1 delay line has been filled with real samples.
module switch_ctrl_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int DELAY      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_0,
    input  logic [DATA_WIDTH-1:0] in_1,
    output logic                  out_valid,
    output logic                  sw_ctrl,
    output logic [DATA_WIDTH-1:0] sw_in_0,
    output logic [DATA_WIDTH-1:0] sw_in_1
);

    // cnt MSB gives (k / DELAY) mod 2; counter wraps naturally at 2*DELAY
    localparam int CW = $clog2(DELAY) + 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dly_q [DELAY];
    logic                  warm;

    logic                  out_valid_q;
    logic                  ctrl_q;
    logic [DATA_WIDTH-1:0] sw0_q;
    logic [DATA_WIDTH-1:0] sw1_q;

    // Phase counter advances once per accepted sample
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) cnt_d = cnt_q + CW'(1);
    end

    // Phase counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Lane-1 delay line; idle cycles leave it untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
        end else if (in_valid) begin
            dly_q[0] <= in_1;
            for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

`ifdef SWITCH_CTRL_WARMUP_MASK_EN
    // Fill counter width must hold the value DELAY itself
    localparam int FW = $clog2(DELAY + 1);

    logic [FW-1:0] fill_q, fill_d;

    // Fill counter saturates once DELAY samples have entered the delay line
    always_comb begin
        fill_d = fill_q;
        if (in_valid && (fill_q != FW'(DELAY))) fill_d = fill_q + FW'(1);
    end

    // Fill counter register
    always_ff @(posedge clk) begin
        if (!rst_n) fill_q <= '0;
        else        fill_q <= fill_d;
    end

    assign warm = (fill_q == FW'(DELAY));
`else
    assign warm = 1'b1;
`endif

    // Output stage: data and ctrl change only on accepted samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= 1'b0;
            sw0_q       <= '0;
            sw1_q       <= '0;
        end else begin
            out_valid_q <= in_valid & warm;
            if (in_valid) begin
                ctrl_q <= cnt_q[CW-1];
                sw0_q  <= in_0;
                sw1_q  <= dly_q[DELAY-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sw_ctrl   = ctrl_q;
    assign sw_in_0   = sw0_q;
    assign sw_in_1   = sw1_q;

endmodule
